dist_frame_tx: RTL and testbench
================================

# dist_frame_tx

Frame packer between the ultrasonic distance measurement stage and the byte-wide UART transmitter. It captures each new distance sample and emits one fixed frame per sample as a byte sequence to the transmitter: header, distance high byte, distance low byte, and an optional checksum. It drives the transmitter through a start-flag/done handshake and inserts the inter-byte guard time. It holds one pending sample so that a measurement arriving mid-frame is not lost.

## Interface
- `CLK`, 50000000, system clock frequency in Hz
- `BAUD`, 115200, line baud rate; `BIT_CYCLES = CLK/BAUD` (integer division)
- `HEADER`, 8'hA5, first byte of every frame
- `clk` input 1 system clock
- `rstn` input 1 asynchronous, active-low reset
- `dist_data` input 16 distance sample, unsigned
- `dist_valid` input 1 one-cycle strobe; `dist_data` is valid in that cycle
- `tx_done` input 1 one-cycle pulse from the transmitter when the current byte's stop bit begins
- `tx_data` output 8 byte presented to the transmitter
- `tx_flag` output 1 one-cycle start pulse for the transmitter
- `busy` output 1 high from frame launch until the last guard interval ends
- `ovr` output 1 one-cycle pulse when a pending sample is overwritten
- `err` output 1 one-cycle pulse when a byte watchdog expires

## Operation
- Reset values: `tx_data`=8'h00, `tx_flag`=0, `busy`=0, `ovr`=0, `err`=0. All registers are cleared, the pending slot is empty, and the FSM is in IDLE.
- Frame layout: `HEADER`, `dist_data[15:8]`, `dist_data[7:0]`, and optionally `CSUM`.
  - `CSUM` = (`HEADER` + hi + lo) mod 256.
  - `FRAME_LEN` is 4 with the checksum and 3 without it.
- On launch, the sample is copied into a frame register. `dist_data` is not referenced again during the frame.
- FSM states:
  - IDLE -> LOAD when `dist_valid` or the pending slot is full. The pending sample has priority and the slot is cleared on launch.
  - LOAD: sets `tx_data` to byte[idx] and pulses `tx_flag`; goes to WAIT_DONE.
  - WAIT_DONE -> GUARD on `tx_done`.
  - WAIT_DONE -> IDLE when the watchdog reaches `12*BIT_CYCLES` without `tx_done`. This pulses `err`, abandons the frame, and clears `busy`; the pending slot is retained.
  - GUARD: counts `BIT_CYCLES` cycles so the stop bit is fully transmitted. At the end it goes to LOAD with idx+1, or to IDLE after idx = `FRAME_LEN-1`.
- `tx_data` is held stable from LOAD until GUARD exits, because the transmitter samples it throughout the byte.
- `dist_valid` while `busy`: the sample is written to the pending slot. If the slot is already full it is overwritten (latest sample wins) and `ovr` pulses.
- `dist_valid` in the same cycle as the final GUARD exit: the sample goes to the pending slot and launches from IDLE on the next cycle.
- `tx_done` in any state other than WAIT_DONE is ignored.
- Arithmetic:
  - The checksum accumulator is 8 bits and wraps modulo 256.
  - The watchdog and guard counters share one counter of width `$clog2(12*BIT_CYCLES+1)`, cleared on every state entry.
  - idx is 2 bits.

## Timing
- `dist_valid` sampled in IDLE at edge N: `tx_flag`=1 and `tx_data`=`HEADER` in cycle N+1; `busy` rises in cycle N+1.
- `tx_flag` is high for exactly one cycle per byte.
- `tx_done` sampled at edge M: the next byte's `tx_flag` is asserted in cycle M+`BIT_CYCLES`+1.
- After the last byte's guard ends, `busy` falls in the following cycle. A pending frame launches one cycle after IDLE is entered.
- Reset deassertion mid-frame: the block resumes in IDLE with no output pulses; the partial frame is not completed.

## Configuration
- `DIST_FRAME_CSUM_EN` defined: frames are 4 bytes and end with `CSUM`.
- `DIST_FRAME_CSUM_EN` undefined: frames are 3 bytes. The accumulator is not built, and idx stops at 2.

## Structure
- The shared package `dist_frame_pkg` holds:
  - the default `HEADER` value;
  - the FSM state enum (IDLE, LOAD, WAIT_DONE, GUARD);
  - the `WDOG_BITS` constant (12);
  - the `FRAME_LEN` derivation, depending on `DIST_FRAME_CSUM_EN`.
- One sub-module is natural: `bit_timer`. It is a loadable down-counter with a `start` input and an `expire` output, used for both the guard and the watchdog intervals.

## Test plan
- `dist_data`=16'h1234 pulse, with a transmitter model returning `tx_done` 10 bit-times after each `tx_flag` -> `tx_data` sequence A5,12,34,EB; each byte spaced by `BIT_CYCLES`+1 cycles after `tx_done`; `busy` low afterwards.
- `dist_data`=16'hFFFF -> bytes A5,FF,FF,A3, confirming the checksum wraps. Without `DIST_FRAME_CSUM_EN` -> A5,FF,FF only.
- During a frame, pulse 16'h0001 then 16'h0002 -> `ovr` pulses once; the next frame carries 00,02 and starts one cycle after `busy` falls.
- Model never returns `tx_done` -> `err` pulses at `12*BIT_CYCLES` cycles after `tx_flag`; the FSM returns to IDLE and `busy`=0.
- Assert `rstn` low during WAIT_DONE of byte 2 -> all outputs at reset values; no further `tx_flag` until a new `dist_valid`.
- `dist_valid` coincident with the final GUARD exit, with value 16'h0BEE -> a second frame A5,0B,EE,9E follows without loss.

Source files
------------

// File: rtl/dist_frame_pkg.sv
// Shared definitions for the distance frame packer.
// Optional checksum byte controlled by macro DIST_FRAME_CSUM_EN.
package dist_frame_pkg;

   localparam logic [7:0] HEADER_DEF = 8'hA5;
   localparam int         WDOG_BITS  = 12;

`ifdef DIST_FRAME_CSUM_EN
   localparam int FRAME_LEN = 4;
`else
   localparam int FRAME_LEN = 3;
`endif

   localparam logic [1:0] LAST_IDX = 2'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      WAIT_DONE = 2'd2,
      GUARD     = 2'd3
   } state_t;

endpackage

// File: rtl/bit_timer.sv
// Loadable down-counter shared by the guard and watchdog intervals.
// expire is high while the count sits at zero.
module bit_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         start,
   input  logic [W-1:0] load_val,
   output logic         expire
);

   logic [W-1:0] cnt_q, cnt_d;

   // Reload on start, otherwise count down and park at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (start)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign expire = (cnt_q == '0);

endmodule

// File: rtl/dist_frame_tx.sv
// Distance frame packer: captures a 16-bit sample and sends
// HEADER, hi, lo (and CSUM when DIST_FRAME_CSUM_EN is defined)
// to a byte UART through a tx_flag/tx_done handshake, with a
// one-bit guard after each stop bit and a per-byte watchdog.
module dist_frame_tx
   import dist_frame_pkg::*;
#(
   parameter int         CLK    = 50000000,
   parameter int         BAUD   = 115200,
   parameter logic [7:0] HEADER = HEADER_DEF
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [15:0] dist_data,
   input  logic        dist_valid,
   input  logic        tx_done,
   output logic [7:0]  tx_data,
   output logic        tx_flag,
   output logic        busy,
   output logic        ovr,
   output logic        err
);

   localparam int BIT_CYCLES = CLK / BAUD;
   localparam int TW         = $clog2(WDOG_BITS * BIT_CYCLES + 1);

   // Loaded one short of the interval: the first counted cycle is the entry cycle,
   // and the watchdog leaves one more cycle for the registered err pulse.
   localparam logic [TW-1:0] GUARD_LOAD = TW'(BIT_CYCLES - 1);
   localparam logic [TW-1:0] WDOG_LOAD  = TW'(WDOG_BITS * BIT_CYCLES - 2);

   state_t       state_q, state_d;
   logic [1:0]   idx_q, idx_d;
   logic [15:0]  frame_q, frame_d;
   logic [15:0]  pend_q, pend_d;
   logic         pend_full_q, pend_full_d;
   logic [7:0]   tx_data_q, tx_data_d;
   logic         busy_q, busy_d;
   logic         ovr_q, ovr_d;
   logic         err_q, err_d;
`ifdef DIST_FRAME_CSUM_EN
   logic [7:0]   csum_q, csum_d;
`endif

   logic [1:0]    nidx;
   logic [7:0]    nbyte;
   logic [15:0]   launch_val;
   logic          tmr_start;
   logic [TW-1:0] tmr_load;
   logic          tmr_expire;

   bit_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rstn     (rstn),
      .start    (tmr_start),
      .load_val (tmr_load),
      .expire   (tmr_expire)
   );

   // Byte that follows the current one in the frame.
   always_comb begin
      nidx = 2'(idx_q + 2'd1);
      case (nidx)
         2'd1:    nbyte = frame_q[15:8];
         2'd2:    nbyte = frame_q[7:0];
`ifdef DIST_FRAME_CSUM_EN
         2'd3:    nbyte = csum_q;
`endif
         default: nbyte = HEADER;
      endcase
   end

   // Next-state, pending slot and output pulse logic.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      idx_d       = idx_q;
      frame_d     = frame_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      tx_data_d   = tx_data_q;
      busy_d      = busy_q;
      ovr_d       = 1'b0;
      err_d       = 1'b0;
      launch_val  = pend_full_q ? pend_q : dist_data;
`ifdef DIST_FRAME_CSUM_EN
      csum_d      = csum_q;
`endif

      // A sample arriving during a frame waits in the slot; latest wins.
      if (dist_valid && busy_q) begin
         pend_d      = dist_data;
         pend_full_d = 1'b1;
         ovr_d       = pend_full_q;
      end

      case (state_q)
         IDLE: begin
            if (pend_full_q || dist_valid) begin
               frame_d   = launch_val;
               idx_d     = 2'd0;
               tx_data_d = HEADER;
               busy_d    = 1'b1;
               state_d   = LOAD;
`ifdef DIST_FRAME_CSUM_EN
               csum_d    = HEADER;
`endif
               // Pending sample launches; a fresh strobe refills the slot behind it.
               if (pend_full_q) begin
                  pend_full_d = dist_valid;
                  if (dist_valid) pend_d = dist_data;
               end
            end
         end
         LOAD: state_d = WAIT_DONE;
         WAIT_DONE: begin
            if (tx_done) begin
               state_d = GUARD;
            end else if (tmr_expire) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               err_d   = 1'b1;
            end
         end
         GUARD: begin
            if (tmr_expire) begin
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end else begin
                  idx_d     = nidx;
                  tx_data_d = nbyte;
                  state_d   = LOAD;
`ifdef DIST_FRAME_CSUM_EN
                  if (nidx != 2'd3) csum_d = csum_q + nbyte;
`endif
               end
            end
         end
         default: state_d = IDLE;
      endcase

      tmr_start = (state_d != state_q);
      tmr_load  = (state_d == GUARD) ? GUARD_LOAD : WDOG_LOAD;
   end

   // State and datapath registers, all cleared by reset including the pending slot.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         idx_q       <= 2'd0;
         frame_q     <= 16'h0000;
         pend_q      <= 16'h0000;
         pend_full_q <= 1'b0;
         tx_data_q   <= 8'h00;
         busy_q      <= 1'b0;
         ovr_q       <= 1'b0;
         err_q       <= 1'b0;
`ifdef DIST_FRAME_CSUM_EN
         csum_q      <= 8'h00;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         frame_q     <= frame_d;
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         tx_data_q   <= tx_data_d;
         busy_q      <= busy_d;
         ovr_q       <= ovr_d;
         err_q       <= err_d;
`ifdef DIST_FRAME_CSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   assign tx_data = tx_data_q;
   assign tx_flag = (state_q == LOAD);
   assign busy    = busy_q;
   assign ovr     = ovr_q;
   assign err     = err_q;

endmodule

// File: tb/tb_dist_frame_tx.sv
// Self-checking bench for dist_frame_tx with a transmitter model
// and a byte scoreboard. Small CLK/BAUD keep bit times short.
module tb_dist_frame_tx;

   localparam int BC = 10;          // 1 MHz / 100 kBd
   localparam int W  = 12 * BC;     // watchdog interval
`ifdef DIST_FRAME_CSUM_EN
   localparam int FLEN = 4;
`else
   localparam int FLEN = 3;
`endif

   logic        clk = 1'b0;
   logic        rstn;
   logic [15:0] dist_data;
   logic        dist_valid;
   logic        tx_done;
   logic [7:0]  tx_data;
   logic        tx_flag;
   logic        busy;
   logic        ovr;
   logic        err;

   dist_frame_tx #(.CLK(1000000), .BAUD(100000)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .dist_data  (dist_data),
      .dist_valid (dist_valid),
      .tx_done    (tx_done),
      .tx_data    (tx_data),
      .tx_flag    (tx_flag),
      .busy       (busy),
      .ovr        (ovr),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] d;
      logic [7:0]  csum;
   } vec_t;

   typedef struct {
      logic [7:0] b;
      bit         first;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   done_cyc = 0, done_cnt = 0;
   int   flag_cnt = 0, first_flag_cyc = 0, launch_gap = 0;
   int   last_fall_cyc = 0;
   int   ovr_cnt = 0, err_cnt = 0, err_cyc = 0;
   int   valid_cyc = 0;
   bit   model_en = 1'b1;
   bit   busy_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_frame(input logic [15:0] d, input logic [7:0] csum);
      exp_q.push_back('{b: 8'hA5, first: 1'b1});
      exp_q.push_back('{b: d[15:8], first: 1'b0});
      exp_q.push_back('{b: d[7:0], first: 1'b0});
      if (FLEN == 4) exp_q.push_back('{b: csum, first: 1'b0});
   endtask

   task automatic send(input logic [15:0] d);
      dist_data  = d;
      dist_valid = 1'b1;
      valid_cyc  = cyc;
      @(negedge clk);
      dist_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("frame_completes", 32'(n < 3000), 32'd1);
      check("busy_low_after", 32'(busy), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_data"}, 32'(tx_data), 32'h00);
      check({tag, "_tx_flag"}, 32'(tx_flag), 32'd0);
      check({tag, "_busy"},    32'(busy),    32'd0);
      check({tag, "_ovr"},     32'(ovr),     32'd0);
      check({tag, "_err"},     32'(err),     32'd0);
   endtask

   // Transmitter model: tx_done about ten bit times after each tx_flag.
   initial begin
      tx_done = 1'b0;
      forever begin
         @(negedge clk);
         tx_done = 1'b0;
         if (tx_flag && model_en) begin
            repeat (10 * BC - 1) @(negedge clk);
            tx_done  = 1'b1;
            done_cyc = cyc + 1;
            done_cnt++;
         end
      end
   end

   // Monitor: scoreboard on every tx_flag, plus pulse and busy tracking.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (tx_flag) begin
            flag_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_tx_flag", 32'(tx_flag), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("tx_data", 32'(tx_data), 32'(e.b));
               if (e.first) begin
                  first_flag_cyc = cyc;
                  launch_gap     = cyc - last_fall_cyc;
               end else begin
                  check("byte_spacing", 32'(cyc - done_cyc), 32'(BC));
               end
            end
         end
         if (ovr) ovr_cnt++;
         if (err) begin
            err_cnt++;
            err_cyc = cyc;
         end
         if (busy_prev && !busy) last_fall_cyc = cyc;
         busy_prev = busy;
      end
   end

   initial begin
      vec_t vecs[4];
      int   base, base2, n;

      vecs[0] = '{d: 16'h1234, csum: 8'hEB};
      vecs[1] = '{d: 16'hFFFF, csum: 8'hA3};
      vecs[2] = '{d: 16'h0BEE, csum: 8'h9E};
      vecs[3] = '{d: 16'h0000, csum: 8'hA5};

      rstn       = 1'b0;
      dist_data  = 16'h0000;
      dist_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("in_reset");
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("after_reset");

      // Table-driven single frames.
      for (int i = 0; i < 4; i++) begin
         push_frame(vecs[i].d, vecs[i].csum);
         send(vecs[i].d);
         wait_idle();
         check("launch_latency", 32'(first_flag_cyc - valid_cyc), 32'd1);
      end
      check("no_ovr_in_table", 32'(ovr_cnt), 32'd0);
      check("no_err_in_table", 32'(err_cnt), 32'd0);

      // Two samples mid-frame: the first is overwritten, the second follows.
      base = ovr_cnt;
      push_frame(16'h1234, 8'hEB);
      send(16'h1234);
      repeat (5) @(negedge clk);
      send(16'h0001);
      repeat (5) @(negedge clk);
      push_frame(16'h0002, 8'hA7);
      send(16'h0002);
      wait_idle();
      check("ovr_once", 32'(ovr_cnt - base), 32'd1);
      check("pending_launch_gap", 32'(launch_gap), 32'd1);

      // Sample coincident with the final guard exit.
      base = done_cnt;
      base2 = ovr_cnt;
      push_frame(16'h5678, 8'h73);
      push_frame(16'h0BEE, 8'h9E);
      send(16'h5678);
      n = 0;
      while (done_cnt < base + FLEN && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("last_done_seen", 32'(n < 2000), 32'd1);
      while (cyc < done_cyc + BC - 1) @(negedge clk);
      send(16'h0BEE);
      wait_idle();
      check("coincident_launch_gap", 32'(launch_gap), 32'd1);
      check("coincident_no_ovr", 32'(ovr_cnt - base2), 32'd0);

      // Watchdog: transmitter never answers.
      model_en = 1'b0;
      base = err_cnt;
      exp_q.push_back('{b: 8'hA5, first: 1'b1});
      send(16'h4321);
      n = 0;
      while (err_cnt == base && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("err_seen", 32'(n < 1000), 32'd1);
      check("err_timing", 32'(err_cyc - first_flag_cyc), 32'(W));
      check("busy_low_on_err", 32'(busy), 32'd0);
      base2 = flag_cnt;
      repeat (50) @(negedge clk);
      check("err_single_pulse", 32'(err_cnt - base), 32'd1);
      check("no_flag_after_err", 32'(flag_cnt - base2), 32'd0);
      check("err_queue_empty", 32'(exp_q.size()), 32'd0);
      model_en = 1'b1;

      // Reset during WAIT_DONE of the second byte.
      base = flag_cnt;
      exp_q.push_back('{b: 8'hA5, first: 1'b1});
      exp_q.push_back('{b: 8'h12, first: 1'b0});
      send(16'h1234);
      n = 0;
      while (flag_cnt < base + 2 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("second_byte_seen", 32'(n < 2000), 32'd1);
      repeat (20) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      check_reset_outputs("mid_reset");
      rstn = 1'b1;
      repeat (300) @(negedge clk);
      check("no_flag_after_reset", 32'(flag_cnt - base), 32'd2);
      check("busy_low_after_reset", 32'(busy), 32'd0);

      // Recovery with a fresh sample.
      push_frame(16'hFFFF, 8'hA3);
      send(16'hFFFF);
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
